// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - memory-stage and downstream request/response bus for dmem_ctrl
interface dmem_ctrl_if;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, mem_byte_enable,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output dmem_resp, dmem_rdata,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask
  );

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, mem_byte_enable,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  dmem_resp, dmem_rdata,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask
  );
endinterface

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - single-outstanding data memory controller with perf counters
// Bridges memory-stage load/store requests onto a valid/ready downstream request port.
module dmem_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_ctrl_if.slave           bus,
  output logic [CNT_WIDTH-1:0] load_count,
  output logic [CNT_WIDTH-1:0] store_count,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic                 protocol_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic                 we_q;
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic [3:0]           wmask_q;
  logic [31:0]          rdata_q;
  logic [CNT_WIDTH-1:0] load_cnt_q;
  logic [CNT_WIDTH-1:0] store_cnt_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic                 perr_q;

  logic req_any;
  logic req_both;
  logic resp_pulse;

  assign req_any  = bus.dmem_read | bus.dmem_write;
  assign req_both = bus.dmem_read & bus.dmem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_any) state_d = S_REQ;
      S_REQ:   if (bus.mem_req_ready) state_d = S_WAIT;
      S_WAIT:  if (bus.mem_rsp_valid) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are masked by rst so nothing leaks out during the reset cycle.
  always_comb begin
    resp_pulse        = (state_q == S_RESP) && !rst;
    bus.mem_req_valid = (state_q == S_REQ) && !rst;
    bus.dmem_resp     = resp_pulse;
    bus.dmem_rdata    = resp_pulse ? rdata_q : 32'h0;
  end

  assign bus.mem_req_we    = we_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_wdata = wdata_q;
  assign bus.mem_req_wmask = wmask_q;

  // A simultaneous read+write is resolved as a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wmask_q <= 4'h0;
      rdata_q <= 32'h0;
    end else begin
      if (state_q == S_IDLE && req_any) begin
        we_q    <= bus.dmem_write;
        addr_q  <= {bus.dmem_address[31:2], 2'b00};
        wdata_q <= bus.dmem_wdata;
        wmask_q <= bus.dmem_write ? bus.mem_byte_enable : 4'h0;
      end
      if (state_q == S_WAIT && bus.mem_rsp_valid) begin
        rdata_q <= bus.mem_rsp_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
      stall_cnt_q <= '0;
      perr_q      <= 1'b0;
    end else begin
      if (resp_pulse && !we_q) load_cnt_q <= load_cnt_q + 1'b1;
      if (resp_pulse && we_q)  store_cnt_q <= store_cnt_q + 1'b1;
      if (req_any && !resp_pulse) stall_cnt_q <= stall_cnt_q + 1'b1;
      if ((state_q == S_IDLE && req_both) ||
          (bus.mem_rsp_valid && state_q != S_WAIT)) begin
        perr_q <= 1'b1;
      end
    end
  end

  assign load_count   = load_cnt_q;
  assign store_count  = store_cnt_q;
  assign stall_count  = stall_cnt_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - scoreboard bench for dmem_ctrl with randomized transactions
module tb_dmem_ctrl;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_ctrl_if bus ();
  logic [CW-1:0] load_count, store_count, stall_count;
  logic          protocol_err;

  dmem_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .load_count   (load_count),
    .store_count  (store_count),
    .stall_count  (stall_count),
    .protocol_err (protocol_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } req_t;

  typedef struct packed {
    logic        we;
    logic [31:0] rdata;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];

  logic [CW-1:0] m_load = '0, m_store = '0, m_stall = '0;
  bit mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=missing expected=present", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: counters follow a cycle-level model; responses and downstream requests are scoreboarded.
  always @(negedge clk) begin : monitor
    rsp_t r;
    req_t q;
    logic got, gwe;
    if (mon_en) begin
      got = 1'b0;
      gwe = 1'b0;
      chk("load_count", 32'(load_count), 32'(m_load));
      chk("store_count", 32'(store_count), 32'(m_store));
      chk("stall_count", 32'(stall_count), 32'(m_stall));
      if (rst) begin
        chk("rst_req_valid", 32'(bus.mem_req_valid), 32'h0);
        chk("rst_resp", 32'(bus.dmem_resp), 32'h0);
        chk("rst_rdata", bus.dmem_rdata, 32'h0);
      end else begin
        if (!bus.dmem_resp) begin
          chk("rdata_zero_when_idle", bus.dmem_rdata, 32'h0);
        end else if (exp_rsp.size() == 0) begin
          fail_now("unexpected_dmem_resp");
        end else begin
          r = exp_rsp.pop_front();
          chk("dmem_rdata", bus.dmem_rdata, r.rdata);
          got = 1'b1;
          gwe = r.we;
        end
        if (bus.mem_req_valid) begin
          if (exp_req.size() == 0) begin
            fail_now("unexpected_mem_req");
          end else begin
            q = exp_req[0];
            chk("mem_req_we", 32'(bus.mem_req_we), 32'(q.we));
            chk("mem_req_addr", bus.mem_req_addr, q.addr);
            chk("mem_req_wdata", bus.mem_req_wdata, q.wdata);
            chk("mem_req_wmask", 32'(bus.mem_req_wmask), 32'(q.mask));
            if (bus.mem_req_ready) void'(exp_req.pop_front());
          end
        end
      end
      if (rst) begin
        m_load  = '0;
        m_store = '0;
        m_stall = '0;
      end else begin
        if ((bus.dmem_read || bus.dmem_write) && !bus.dmem_resp) m_stall = m_stall + 1'b1;
        if (got && gwe)  m_store = m_store + 1'b1;
        if (got && !gwe) m_load  = m_load + 1'b1;
      end
    end
  end

  task automatic idle_inputs();
    bus.dmem_read       = 1'b0;
    bus.dmem_write      = 1'b0;
    bus.mem_req_ready   = 1'b0;
    bus.mem_rsp_valid   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    exp_req.delete();
    exp_rsp.delete();
    step();
    rst = 1'b0;
  endtask

  task automatic do_txn(input bit we, input bit both, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] rdata, input int rdy_dly,
                        input int rsp_dly, input bit keep);
    logic eff_we;
    int   n;
    eff_we               = we | both;
    bus.dmem_read        = !we | both;
    bus.dmem_write       = eff_we;
    bus.dmem_address     = addr;
    bus.dmem_wdata       = wdata;
    bus.mem_byte_enable  = be;
    bus.mem_req_ready    = 1'b0;
    exp_req.push_back('{eff_we, {addr[31:2], 2'b00}, wdata, eff_we ? be : 4'h0});
    exp_rsp.push_back('{eff_we, rdata});
    n = 0;
    step();
    while (!bus.mem_req_valid && n < 8) begin
      step();
      n++;
    end
    if (!bus.mem_req_valid) begin
      fail_now("req_valid_timeout");
      idle_inputs();
      return;
    end
    repeat (rdy_dly) step();
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    repeat (rsp_dly) step();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = rdata;
    step();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = $urandom;
    chk("resp_latency", 32'(bus.dmem_resp), 32'h1);
    if (!keep) begin
      bus.dmem_read  = 1'b0;
      bus.dmem_write = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.dmem_address    = 32'h0;
    bus.dmem_wdata      = 32'h0;
    bus.mem_byte_enable = 4'h0;
    bus.mem_rsp_rdata   = 32'h0;
    repeat (2) step();
    mon_en = 1;
    chk("reset_perr", 32'(protocol_err), 32'h0);
    chk("reset_load", 32'(load_count), 32'h0);
    rst = 1'b0;
    step();
    chk("post_reset_valid", 32'(bus.mem_req_valid), 32'h0);
    chk("post_reset_resp", 32'(bus.dmem_resp), 32'h0);

    // Zero-wait load
    do_txn(1'b0, 1'b0, 32'h0000_1006, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
    step();
    chk("zw_load_count", 32'(load_count), 32'h1);
    chk("zw_stall_count", 32'(stall_count), 32'h3);
    chk("zw_resp_width", 32'(bus.dmem_resp), 32'h0);

    // Backpressured store
    do_txn(1'b1, 1'b0, 32'h0000_2003, 32'hAA00_0000, 4'b1000, 32'h0, 4, 0, 1'b0);
    step();
    chk("bp_store_count", 32'(store_count), 32'h1);

    // Back-to-back loads held through their own response
    do_txn(1'b0, 1'b0, 32'h0000_3000, 32'h1, 4'h0, 32'h1111_2222, 0, 0, 1'b1);
    do_txn(1'b0, 1'b0, 32'h0000_3004, 32'h2, 4'h0, 32'h3333_4444, 1, 1, 1'b0);
    step();
    chk("b2b_load_count", 32'(load_count), 32'h3);

    for (int i = 0; i < 40; i++) begin
      do_txn(1'($urandom), 1'b0, $urandom, $urandom, 4'($urandom), $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom));
      if (!bus.dmem_read && !bus.dmem_write) repeat ($urandom_range(0, 2)) step();
    end
    idle_inputs();
    repeat (2) step();
    chk("random_no_perr", 32'(protocol_err), 32'h0);

    // Counter wrap after 16 loads
    do_reset();
    for (int i = 0; i < 16; i++) begin
      do_txn(1'b0, 1'b0, $urandom, $urandom, 4'h0, $urandom, 0, 0, 1'b0);
    end
    step();
    chk("wrap_load_count", 32'(load_count), 32'h0);

    // Read and write together
    do_reset();
    do_txn(1'b0, 1'b1, 32'h0000_4001, 32'h5555_AAAA, 4'b0110, 32'h7, 0, 0, 1'b0);
    chk("both_perr", 32'(protocol_err), 32'h1);
    step();
    chk("both_store_count", 32'(store_count), 32'h1);

    // Reset while waiting for a response, then a stray response
    do_reset();
    do_txn(1'b1, 1'b0, 32'h0000_5000, 32'h9, 4'hF, 32'h0, 0, 0, 1'b0);
    bus.dmem_read    = 1'b1;
    bus.dmem_address = 32'h0000_6008;
    exp_req.push_back('{1'b0, 32'h0000_6008, bus.dmem_wdata, 4'h0});
    step();
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    bus.dmem_read     = 1'b0;
    rst = 1'b1;
    exp_req.delete();
    step();
    rst = 1'b0;
    chk("rw_valid", 32'(bus.mem_req_valid), 32'h0);
    chk("rw_resp", 32'(bus.dmem_resp), 32'h0);
    chk("rw_rdata", bus.dmem_rdata, 32'h0);
    chk("rw_store", 32'(store_count), 32'h0);
    chk("rw_perr", 32'(protocol_err), 32'h0);
    repeat (2) step();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'hBAD0_BAD0;
    step();
    bus.mem_rsp_valid = 1'b0;
    chk("stray_no_resp", 32'(bus.dmem_resp), 32'h0);
    chk("stray_perr", 32'(protocol_err), 32'h1);
    repeat (3) step();
    chk("perr_sticky", 32'(protocol_err), 32'h1);
    chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
- REQ-001: Parameter CNT_WIDTH, default 32: width of each performance counter.
- REQ-002: clk  input  1  sole clock; all state updates on the rising edge.
- REQ-003: rst  input  1  reset, synchronous and active-high.
- REQ-004: dmem_read  input  1  load request from the memory stage, held high until dmem_resp.
- REQ-005: dmem_write  input  1  store request from the memory stage, held high until dmem_resp.
- REQ-006: dmem_address  input  32  byte address from the memory stage.
- REQ-007: dmem_wdata  input  32  store data, already lane-aligned.
- REQ-008: mem_byte_enable  input  4  store byte lanes.
- REQ-009: dmem_resp  output  1  one-cycle completion pulse to the memory stage.
- REQ-010: dmem_rdata  output  32  load data, valid while dmem_resp=1.
- REQ-011: mem_req_valid  output  1  downstream request valid.
- REQ-012: mem_req_ready  input  1  downstream request accept.
- REQ-013: mem_req_we  output  1  1=write, 0=read.
- REQ-014: mem_req_addr  output  32  word-aligned address.
- REQ-015: mem_req_wdata  output  32  write data.
- REQ-016: mem_req_wmask  output  4  write byte mask.
- REQ-017: mem_rsp_valid  input  1  downstream response (read data or write ack), one cycle.
- REQ-018: mem_rsp_rdata  input  32  downstream read data, valid with mem_rsp_valid.
- REQ-019: load_count, store_count, stall_count  output  CNT_WIDTH each  performance counters.
- REQ-020: protocol_err  output  1  sticky protocol-violation flag.

Function
- REQ-021: FSM states IDLE, REQ, WAIT, RESP; only one transaction outstanding.
- REQ-022: IDLE and (dmem_read or dmem_write) -> REQ; latch we, {dmem_address[31:2],2'b00}, dmem_wdata, and mask (mem_byte_enable for writes, 4'b0000 for reads) into request registers.
- REQ-023: Both dmem_read and dmem_write high in IDLE -> write issued, protocol_err set.
- REQ-024: mem_req_valid=1 only in REQ; mem_req_* are driven from the latched registers and stay stable until mem_req_ready.
- REQ-025: REQ and mem_req_ready -> WAIT; REQ and not mem_req_ready -> stay in REQ.
- REQ-026: WAIT and mem_rsp_valid -> RESP; latch mem_rsp_rdata (also for writes).
- REQ-027: mem_rsp_valid in any state other than WAIT is ignored for data and sets protocol_err.
- REQ-028: RESP: dmem_resp=1 and dmem_rdata=latched data for exactly one cycle; next state IDLE unconditionally.
- REQ-029: dmem_rdata=0 whenever dmem_resp=0.
- REQ-030: Minimum latency is 3 cycles: request first seen in cycle 0, ready=1 in cycle 1, rsp_valid in cycle 2, dmem_resp in cycle 3.
- REQ-031: A request still asserted in IDLE after RESP starts a new transaction; no deduplication.
- REQ-032: load_count increments by 1 in each RESP cycle of a read transaction.
- REQ-033: store_count increments by 1 in each RESP cycle of a write transaction.
- REQ-034: stall_count increments by 1 in each cycle where (dmem_read or dmem_write)=1 and dmem_resp=0.
- REQ-035: All counters wrap modulo 2^CNT_WIDTH with no saturation.
- REQ-036: protocol_err stays 1 until reset.

Reset
- REQ-037: rst=1 at a clock edge -> state IDLE; request and data registers 0; counters 0; protocol_err 0. This holds from any state, including REQ or WAIT.
- REQ-038: During and in the cycle after reset: mem_req_valid=0, dmem_resp=0, dmem_rdata=0.
- REQ-039: After reset, the downstream side must not deliver a response for a transaction abandoned by reset; such a response sets protocol_err.

Verification
- REQ-040: Zero-wait load: dmem_read=1, dmem_address=0x0000_1006; ready=1 at cycle 1; rsp_valid with rdata=0xDEADBEEF at cycle 2 -> mem_req_addr=0x0000_1004, we=0, wmask=0; dmem_resp=1, dmem_rdata=0xDEADBEEF at cycle 3 only; load_count=1; stall_count=3.
- REQ-041: Backpressured store: dmem_write=1, address 0x2003, wdata 0xAA000000, byte_enable 4'b1000; ready low 4 cycles -> mem_req_* stable for all 5 REQ cycles; addr 0x2000; wmask 4'b1000; after ack, store_count=1.
- REQ-042: Back-to-back: two loads in succession, each held until its own resp -> two distinct downstream requests; load_count=2; no dmem_resp pulse wider than one cycle.
- REQ-043: Reset in WAIT: rst=1 for one cycle while in WAIT -> next cycle IDLE, all outputs and counters 0; a later rsp_valid with no request outstanding -> protocol_err=1, no dmem_resp.
- REQ-044: Illegal stimulus: dmem_read=dmem_write=1 in IDLE -> mem_req_we=1 and protocol_err=1.
- REQ-045: Counter wrap: with CNT_WIDTH=4, 16 loads -> load_count returns to 0.
